// File: rtl/ctrl_fsm_mac_pkg.sv
// Shared definitions for the SMAC MAC-job controller: state encoding and default geometry.
package ctrl_fsm_mac_pkg;

    localparam int unsigned PA_DEFAULT  = 8;
    localparam int unsigned NPW_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_ACC  = 3'd2,
        ST_WB   = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } ctrl_mac_state_t;

endpackage

// File: rtl/ctrl_mod_cnt.sv
// Generic up-counter with clear, enable and terminal compare; optionally wraps to zero
// when enabled while sitting on the terminal value.
module ctrl_mod_cnt #(
    parameter int unsigned W    = 4,
    parameter bit          WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         at_term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_term_o = (cnt_q == term_i);
    assign cnt_o     = cnt_q;

    // Clear beats enable so an abort or a new pass always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (WRAP && at_term_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ctrl_fsm_mac.sv
// Control FSM for one MAC accumulation job: clear, Pa-beat accumulate into AC1,
// write back to AC2 and hand the result off, repeated for num_pass passes.
module ctrl_fsm_mac
    import ctrl_fsm_mac_pkg::*;
#(
    parameter int unsigned Pa  = PA_DEFAULT,
    parameter int unsigned NPW = NPW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NPW-1:0]       num_pass,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic                 out_ready,
    output logic                 in_ready,
    output logic                 ac1_en,
    output logic                 ac1_cnt,
    output logic                 cnt_clear,
    output logic                 acc_clr,
    output logic                 ac2_en,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(Pa):0]  beat_idx,
    output logic [NPW-1:0]       pass_idx
);

    localparam int unsigned BW = $clog2(Pa) + 1;

    ctrl_mac_state_t state_q;
    ctrl_mac_state_t state_d;
    logic [NPW-1:0]  num_pass_q;
    logic [NPW-1:0]  num_pass_d;

    logic beat_clr;
    logic beat_last;
    logic pass_clr;
    logic pass_inc;
    logic pass_last;

    // Beat counter wraps on the last beat so it never registers Pa.
    ctrl_mod_cnt #(
        .W    (BW),
        .WRAP (1'b1)
    ) u_beat_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (beat_clr),
        .en_i      (ac1_cnt),
        .term_i    (BW'(Pa - 1)),
        .cnt_o     (beat_idx),
        .at_term_o (beat_last)
    );

    // Terminal is num_pass-1 so the compare flags the handshake that completes the job.
    ctrl_mod_cnt #(
        .W    (NPW),
        .WRAP (1'b0)
    ) u_pass_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (pass_clr),
        .en_i      (pass_inc),
        .term_i    (num_pass_q - NPW'(1)),
        .cnt_o     (pass_idx),
        .at_term_o (pass_last)
    );

    always_comb begin
        state_d    = state_q;
        num_pass_d = num_pass_q;
        in_ready   = 1'b0;
        ac1_en     = 1'b0;
        ac1_cnt    = 1'b0;
        cnt_clear  = 1'b0;
        acc_clr    = 1'b0;
        ac2_en     = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        beat_clr   = 1'b0;
        pass_clr   = 1'b0;
        pass_inc   = 1'b0;
        busy       = (state_q != ST_IDLE);

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
            beat_clr  = 1'b1;
            pass_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_pass_d = num_pass;
                        pass_clr   = 1'b1;
                        state_d    = (num_pass == '0) ? ST_DONE : ST_CLR;
                    end
                end
                ST_CLR: begin
                    cnt_clear = 1'b1;
                    acc_clr   = 1'b1;
                    beat_clr  = 1'b1;
                    state_d   = ST_ACC;
                end
                ST_ACC: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        ac1_en  = 1'b1;
                        ac1_cnt = 1'b1;
                        if (beat_last) begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    ac2_en  = 1'b1;
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        pass_inc = 1'b1;
                        state_d  = pass_last ? ST_DONE : ST_CLR;
                    end
                end
                ST_DONE: begin
                    done     = 1'b1;
                    pass_clr = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_pass_q <= '0;
        end else begin
            state_q    <= state_d;
            num_pass_q <= num_pass_d;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm_mac.sv
// Scoreboard bench for ctrl_fsm_mac: stimulus queues expected events, a negedge monitor
// pops and compares them as the DUT presents CLR/WB/handshake/DONE/abort strobes.
module tb_ctrl_fsm_mac;

    localparam int PA  = 8;
    localparam int NPW = 8;
    localparam int K_CLR = 0, K_WB = 1, K_HS = 2, K_DONE = 3, K_ABT = 4;
    localparam int I_EN = 0, I_CNT = 1, I_CLR = 2, I_AC2 = 3, I_OV = 4, I_DONE = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [NPW-1:0] num_pass = '0;
    logic           abort = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready, ac1_en, ac1_cnt, cnt_clear, acc_clr, ac2_en, out_valid, busy, done;
    logic [3:0]     beat_idx;
    logic [NPW-1:0] pass_idx;
    logic [20:0]    outvec;

    assign outvec = {in_ready, ac1_en, ac1_cnt, cnt_clear, acc_clr, ac2_en, out_valid,
                     busy, done, beat_idx, pass_idx};

    ctrl_fsm_mac #(.Pa(PA), .NPW(NPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_pass  (num_pass),
        .abort     (abort),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .ac1_en    (ac1_en),
        .ac1_cnt   (ac1_cnt),
        .cnt_clear (cnt_clear),
        .acc_clr   (acc_clr),
        .ac2_en    (ac2_en),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .beat_idx  (beat_idx),
        .pass_idx  (pass_idx)
    );

    typedef struct {
        int kind;
        int cyc;
        int pidx;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  tot[6] = '{0, 0, 0, 0, 0, 0};
    int  s[6];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    function automatic void push(input int k, input int c, input int p);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.pidx = p;
        exp_q.push_back(e);
    endfunction

    function automatic void chk_event(input int k);
        ev_t e;
        int  rel;
        rel = cyc - t0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got unexpected kind %0d at rel %0d, expected none", k, rel);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (e.cyc >= 0 && e.cyc != rel) || e.pidx != int'(pass_idx)) begin
                errors++;
                $display("FAIL event: got kind %0d rel %0d pass_idx %0d, expected kind %0d rel %0d pass_idx %0d",
                         k, rel, pass_idx, e.kind, e.cyc, e.pidx);
            end
        end
    endfunction

    // Monitor: tallies strobes and checks every event against the scoreboard.
    initial forever begin
        @(negedge clk);
        tot[I_EN]   += int'(ac1_en);
        tot[I_CNT]  += int'(ac1_cnt);
        tot[I_CLR]  += int'(cnt_clear);
        tot[I_AC2]  += int'(ac2_en);
        tot[I_OV]   += int'(out_valid);
        tot[I_DONE] += int'(done);
        if (cnt_clear) chk_event(abort ? K_ABT : K_CLR);
        if (ac2_en) chk_event(K_WB);
        if (out_valid && out_ready) chk_event(K_HS);
        if (done) chk_event(K_DONE);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int np);
        num_pass = NPW'(np);
        start    = 1'b1;
        t0       = cyc;
        tick();
        start    = 1'b0;
    endtask

    function automatic int d(input int i);
        return tot[i] - s[i];
    endfunction

    task automatic run_clean(input string tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        push(K_CLR, 1, 0);
        push(K_WB, 10, 0);
        push(K_HS, 11, 0);
        push(K_DONE, 12, 1);
        s = tot;
        go(1);
        num_pass = 8'd5;
        repeat (12) tick();
        check({tag, ".busy_low"}, int'(busy), 0);
        check({tag, ".ac1_cnt"}, d(I_CNT), 8);
        check({tag, ".ac1_en"}, d(I_EN), 8);
        check({tag, ".cnt_clear"}, d(I_CLR), 1);
        check({tag, ".ac2_en"}, d(I_AC2), 1);
        check({tag, ".out_valid"}, d(I_OV), 1);
        check({tag, ".done"}, d(I_DONE), 1);
        check({tag, ".queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sa;
        #1 rst_n = 1'b0;
        #2;
        check("reset.outputs", int'(outvec), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_clean("t1");

        // Three passes with in_valid low every other cycle.
        for (int p = 0; p < 3; p++) begin
            push(K_CLR, -1, p);
            push(K_WB, -1, p);
            push(K_HS, -1, p);
        end
        push(K_DONE, -1, 3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        s = tot;
        go(3);
        n = 0;
        while (d(I_DONE) == 0 && n < 400) begin
            in_valid = ~in_valid;
            tick();
            n++;
        end
        in_valid = 1'b1;
        check("t2.timeout", int'(n < 400), 1);
        check("t2.ac1_en", d(I_EN), 24);
        check("t2.cnt_clear", d(I_CLR), 3);
        check("t2.handshakes", d(I_OV), 3);
        check("t2.done", d(I_DONE), 1);
        check("t2.pass_idx_idle", int'(pass_idx), 0);
        check("t2.busy_low", int'(busy), 0);
        check("t2.queue", exp_q.size(), 0);

        // out_ready low for five OUT cycles.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        push(K_CLR, 1, 0);
        push(K_WB, 10, 0);
        push(K_HS, 16, 0);
        push(K_DONE, 17, 1);
        s = tot;
        go(1);
        repeat (10) tick();
        sa = tot[I_EN];
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        check("t3.ac1_en_stall", tot[I_EN] - sa, 0);
        tick();
        check("t3.out_valid_cycles", d(I_OV), 6);
        check("t3.ac2_en", d(I_AC2), 1);
        check("t3.ac1_en", d(I_EN), 8);
        check("t3.busy_low", int'(busy), 0);
        check("t3.queue", exp_q.size(), 0);

        // Abort in ACC after four beats, then a clean pass.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        push(K_CLR, 1, 0);
        push(K_ABT, 6, 0);
        s = tot;
        go(2);
        repeat (5) tick();
        check("t4.beat_idx_pre", int'(beat_idx), 4);
        abort = 1'b1;
        #1;
        check("t4.cnt_clear", int'(cnt_clear), 1);
        check("t4.ac1_en_masked", int'(ac1_en), 0);
        check("t4.in_ready_masked", int'(in_ready), 0);
        tick();
        abort = 1'b0;
        check("t4.busy_low", int'(busy), 0);
        check("t4.beat_idx", int'(beat_idx), 0);
        check("t4.ac1_en", d(I_EN), 4);
        check("t4.done", d(I_DONE), 0);
        check("t4.queue", exp_q.size(), 0);
        run_clean("t4b");

        // num_pass = 0 goes straight to DONE.
        push(K_DONE, 1, 0);
        s = tot;
        go(0);
        tick();
        check("t5.busy_low", int'(busy), 0);
        check("t5.ac1_cnt", d(I_CNT), 0);
        check("t5.cnt_clear", d(I_CLR), 0);
        check("t5.ac2_en", d(I_AC2), 0);
        check("t5.out_valid", d(I_OV), 0);
        check("t5.done", d(I_DONE), 1);
        check("t5.queue", exp_q.size(), 0);

        // start while busy is ignored.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        push(K_CLR, 1, 0);
        push(K_WB, 10, 0);
        push(K_HS, 11, 0);
        push(K_DONE, 12, 1);
        s = tot;
        go(1);
        tick();
        num_pass = 8'd2;
        start    = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (8) tick();
        check("t7.busy_low", int'(busy), 0);
        check("t7.cnt_clear", d(I_CLR), 1);
        check("t7.done", d(I_DONE), 1);
        check("t7.queue", exp_q.size(), 0);

        // Reset mid-OUT drops the job.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        push(K_CLR, 1, 0);
        push(K_WB, 10, 0);
        s = tot;
        go(1);
        repeat (11) tick();
        check("t6.out_valid_pre", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("t6.outputs_async", int'(outvec), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6.busy_low", int'(busy), 0);
        check("t6.done", d(I_DONE), 0);
        check("t6.queue", exp_q.size(), 0);
        run_clean("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
